// File: rtl/rename_free_list_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rename_free_list_ctrl_if : rename allocate / commit free / status bundle    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface rename_free_list_ctrl_if #(
  parameter int NUM_PHYSICAL_REGISTERS = 64,
  parameter int PREG_W                 = 6
);
  logic                              alloc_valid;
  logic                              alloc_req1;
  logic                              alloc_req2;
  logic                              alloc_ready;
  logic [PREG_W-1:0]                 alloc_prd1;
  logic [PREG_W-1:0]                 alloc_prd2;
  logic                              commit_valid1;
  logic                              commit_valid2;
  logic [PREG_W-1:0]                 commit_prd1;
  logic [PREG_W-1:0]                 commit_prd2;
  logic [PREG_W-1:0]                 commit_old1;
  logic [PREG_W-1:0]                 commit_old2;
  logic                              flush;
  logic [NUM_PHYSICAL_REGISTERS-1:0] free_pool;
  logic [PREG_W:0]                   free_count;
  logic                              dbl_free_err;

  modport master (
    output alloc_valid, alloc_req1, alloc_req2,
    output commit_valid1, commit_valid2, commit_prd1, commit_prd2,
    output commit_old1, commit_old2, flush,
    input  alloc_ready, alloc_prd1, alloc_prd2,
    input  free_pool, free_count, dbl_free_err
  );

  modport slave (
    input  alloc_valid, alloc_req1, alloc_req2,
    input  commit_valid1, commit_valid2, commit_prd1, commit_prd2,
    input  commit_old1, commit_old2, flush,
    output alloc_ready, alloc_prd1, alloc_prd2,
    output free_pool, free_count, dbl_free_err
  );
endinterface
`default_nettype wire

// File: rtl/rename_free_list_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rename_free_list_ctrl : speculative/committed physical register free pools |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rename_free_list_ctrl #(
  parameter int NUM_PHYSICAL_REGISTERS = 64,
  parameter int PREG_W                 = 6
) (
  input wire                     clk,
  input wire                     reset,
  rename_free_list_ctrl_if.slave bus
);

  localparam int c_cnt_w = PREG_W + 1;
  localparam logic [NUM_PHYSICAL_REGISTERS-1:0] c_reset_pool =
    {{(NUM_PHYSICAL_REGISTERS-32){1'b1}}, 32'b0};
  localparam logic [PREG_W:0] c_reset_count = c_cnt_w'(NUM_PHYSICAL_REGISTERS - 32);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t                            r_state;
  logic [NUM_PHYSICAL_REGISTERS-1:0] r_spec;
  logic [NUM_PHYSICAL_REGISTERS-1:0] r_comm;
  logic [PREG_W:0]                   r_count;
  logic                              r_err;

  logic [PREG_W-1:0]                 w_first;
  logic [PREG_W-1:0]                 w_second;
  logic [1:0]                        w_hits;
  logic [1:0]                        w_need;
  logic                              w_ready;
  logic                              w_transfer;
  logic [PREG_W-1:0]                 w_prd1;
  logic [PREG_W-1:0]                 w_prd2;
  logic [NUM_PHYSICAL_REGISTERS-1:0] w_grant_mask;
  logic [1:0]                        w_n_grant;

  logic [1:0]                        w_cv;
  logic [1:0][PREG_W-1:0]            w_cprd;
  logic [1:0][PREG_W-1:0]            w_cold;
  logic [NUM_PHYSICAL_REGISTERS-1:0] w_comm_next;
  logic [NUM_PHYSICAL_REGISTERS-1:0] w_spec_freed;
  logic [NUM_PHYSICAL_REGISTERS-1:0] w_spec_next;
  logic [1:0]                        w_n_freed;
  logic                              w_dbl;
  logic [PREG_W:0]                   w_count_next;

  function automatic logic [PREG_W:0] popcount(input logic [NUM_PHYSICAL_REGISTERS-1:0] v);
    logic [PREG_W:0] n;
    n = '0;
    for (int i = 0; i < NUM_PHYSICAL_REGISTERS; i++) begin
      n = n + {{PREG_W{1'b0}}, v[i]};
    end
    return n;
  endfunction

  // Lowest and second-lowest free tags; p0 is never a candidate.
  always_comb begin
    w_first  = '0;
    w_second = '0;
    w_hits   = '0;
    for (int i = 1; i < NUM_PHYSICAL_REGISTERS; i++) begin
      if (r_spec[i]) begin
        if (w_hits == 2'd0) begin
          w_first = PREG_W'(i);
        end else if (w_hits == 2'd1) begin
          w_second = PREG_W'(i);
        end
        if (w_hits != 2'd2) begin
          w_hits = w_hits + 2'd1;
        end
      end
    end
  end

  assign w_need     = {1'b0, bus.alloc_req1} + {1'b0, bus.alloc_req2};
  assign w_ready    = (r_state == ST_RUN) && !bus.flush && (r_count >= c_cnt_w'(w_need));
  assign w_transfer = bus.alloc_valid && w_ready;
  assign w_prd1     = bus.alloc_req1 ? w_first : '0;
  assign w_prd2     = bus.alloc_req2 ? (bus.alloc_req1 ? w_second : w_first) : '0;
  assign w_n_grant  = w_transfer ? w_need : 2'd0;

  always_comb begin
    w_grant_mask = '0;
    if (w_transfer) begin
      if (bus.alloc_req1) w_grant_mask[w_prd1] = 1'b1;
      if (bus.alloc_req2) w_grant_mask[w_prd2] = 1'b1;
    end
  end

  assign w_cv   = {bus.commit_valid2, bus.commit_valid1};
  assign w_cprd = {bus.commit_prd2, bus.commit_prd1};
  assign w_cold = {bus.commit_old2, bus.commit_old1};

  // Slot 1 then slot 2, so slot 2 wins same-tag conflicts and a repeated tag
  // within the cycle is caught as a double free.
  always_comb begin
    w_comm_next  = r_comm;
    w_spec_freed = r_spec;
    w_dbl        = 1'b0;
    w_n_freed    = '0;
    for (int k = 0; k < 2; k++) begin
      if (w_cv[k]) begin
        if (w_cprd[k] != '0) w_comm_next[w_cprd[k]] = 1'b0;
        if (w_cold[k] != '0) begin
          w_comm_next[w_cold[k]] = 1'b1;
          if (w_spec_freed[w_cold[k]]) begin
            w_dbl = 1'b1;
          end else begin
            w_n_freed = w_n_freed + 2'd1;
          end
          w_spec_freed[w_cold[k]] = 1'b1;
        end
      end
    end
    w_comm_next[0] = 1'b0;
    w_spec_next    = bus.flush ? w_comm_next : (w_spec_freed & ~w_grant_mask);
    w_spec_next[0] = 1'b0;
  end

  assign w_count_next = bus.flush ? popcount(w_comm_next)
                      : (r_count - c_cnt_w'(w_n_grant) + c_cnt_w'(w_n_freed));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_spec  <= c_reset_pool;
      r_comm  <= c_reset_pool;
      r_count <= c_reset_count;
      r_err   <= 1'b0;
    end else begin
      r_spec  <= w_spec_next;
      r_comm  <= w_comm_next;
      r_count <= w_count_next;
      if (w_dbl) r_err <= 1'b1;
      case (r_state)
        ST_INIT:    r_state <= bus.flush ? ST_RECOVER : ST_RUN;
        ST_RUN:     r_state <= bus.flush ? ST_RECOVER : ST_RUN;
        ST_RECOVER: r_state <= bus.flush ? ST_RECOVER : ST_RUN;
        default:    r_state <= ST_INIT;
      endcase
    end
  end

  assign bus.alloc_ready  = w_ready;
  assign bus.alloc_prd1   = w_prd1;
  assign bus.alloc_prd2   = w_prd2;
  assign bus.free_pool    = r_spec;
  assign bus.free_count   = r_count;
  assign bus.dbl_free_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rename_free_list_ctrl.sv
`default_nettype none
// Directed bench for rename_free_list_ctrl against a pool-level reference model.
module tb_rename_free_list_ctrl;
  localparam int NPR = 64;
  localparam int PW  = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rename_free_list_ctrl_if #(.NUM_PHYSICAL_REGISTERS(NPR), .PREG_W(PW)) bus ();
  rename_free_list_ctrl #(.NUM_PHYSICAL_REGISTERS(NPR), .PREG_W(PW)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  logic [NPR-1:0] m_spec;
  logic [NPR-1:0] m_comm;
  bit m_run = 1'b0;
  bit m_err = 1'b0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pop(input logic [NPR-1:0] v);
    int n = 0;
    for (int i = 0; i < NPR; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int nth_free(input logic [NPR-1:0] v, input int k);
    int seen = 0;
    for (int i = 1; i < NPR; i++) begin
      if (v[i]) begin
        if (seen == k) return i;
        seen++;
      end
    end
    return 0;
  endfunction

  // Reference model: pools as plain bit arrays; RUN resumes the cycle after any non-flush, non-reset edge.
  always @(posedge clk) begin
    int need, a, b;
    bit go;
    logic [NPR-1:0] nxt;
    bit vals [2];
    int prds [2];
    int olds [2];
    if (reset) begin
      m_spec  = {{(NPR-32){1'b1}}, 32'b0};
      m_comm  = m_spec;
      m_run   = 1'b0;
      m_err   = 1'b0;
      started = 1'b1;
    end else if (started) begin
      need = int'(bus.alloc_req1) + int'(bus.alloc_req2);
      go   = bus.alloc_valid && m_run && !bus.flush && (pop(m_spec) >= need);
      a    = nth_free(m_spec, 0);
      b    = nth_free(m_spec, 1);
      nxt  = m_spec;
      vals[0] = bus.commit_valid1; prds[0] = int'(bus.commit_prd1); olds[0] = int'(bus.commit_old1);
      vals[1] = bus.commit_valid2; prds[1] = int'(bus.commit_prd2); olds[1] = int'(bus.commit_old2);
      for (int k = 0; k < 2; k++) begin
        if (vals[k]) begin
          if (prds[k] != 0) m_comm[prds[k]] = 1'b0;
          if (olds[k] != 0) begin
            if (nxt[olds[k]]) m_err = 1'b1;
            nxt[olds[k]] = 1'b1;
            m_comm[olds[k]] = 1'b1;
          end
        end
      end
      if (go && need == 2) begin
        nxt[a] = 1'b0;
        nxt[b] = 1'b0;
      end else if (go && need == 1) begin
        nxt[a] = 1'b0;
      end
      m_spec = bus.flush ? m_comm : nxt;
      m_run  = !bus.flush;
    end
  end

  always @(negedge clk) begin
    int need, fc, e1, e2;
    bit er;
    if (started) begin
      need = int'(bus.alloc_req1) + int'(bus.alloc_req2);
      fc   = pop(m_spec);
      er   = m_run && !bus.flush && (fc >= need);
      chk("alloc_ready", 64'(bus.alloc_ready), 64'(er));
      chk("free_pool", bus.free_pool, m_spec);
      chk("free_count", 64'(bus.free_count), 64'(fc));
      chk("dbl_free_err", 64'(bus.dbl_free_err), 64'(m_err));
      if (fc >= need) begin
        e1 = bus.alloc_req1 ? nth_free(m_spec, 0) : 0;
        e2 = bus.alloc_req2 ? (bus.alloc_req1 ? nth_free(m_spec, 1) : nth_free(m_spec, 0)) : 0;
        chk("alloc_prd1", 64'(bus.alloc_prd1), 64'(e1));
        chk("alloc_prd2", 64'(bus.alloc_prd2), 64'(e2));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic set_alloc(input bit v, input bit r1, input bit r2);
    bus.alloc_valid = v;
    bus.alloc_req1  = r1;
    bus.alloc_req2  = r2;
  endtask

  task automatic set_commit(input int k, input bit v, input int prd, input int old);
    if (k == 1) begin
      bus.commit_valid1 = v; bus.commit_prd1 = PW'(prd); bus.commit_old1 = PW'(old);
    end else begin
      bus.commit_valid2 = v; bus.commit_prd2 = PW'(prd); bus.commit_old2 = PW'(old);
    end
  endtask

  task automatic idle();
    set_alloc(0, 0, 0);
    set_commit(1, 0, 0, 0);
    set_commit(2, 0, 0, 0);
    bus.flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sample();
    chk("init_not_ready", 64'(bus.alloc_ready), 64'd0);

    step(); set_alloc(1, 1, 1); sample();
    chk("first_ready", 64'(bus.alloc_ready), 64'd1);
    chk("grant_pair_prd1", 64'(bus.alloc_prd1), 64'd32);
    chk("grant_pair_prd2", 64'(bus.alloc_prd2), 64'd33);

    step(); set_alloc(1, 0, 1); sample();
    chk("count_after_pair", 64'(bus.free_count), 64'd30);
    chk("pool_b32_taken", 64'(bus.free_pool[32]), 64'd0);
    chk("pool_b33_taken", 64'(bus.free_pool[33]), 64'd0);
    chk("slot2_only_prd2", 64'(bus.alloc_prd2), 64'd34);
    chk("slot2_only_prd1", 64'(bus.alloc_prd1), 64'd0);

    step(); set_alloc(1, 1, 1); sample();
    chk("single_clear_count", 64'(bus.free_count), 64'd29);
    repeat (13) step();
    step(); set_commit(1, 1, 32, 5); sample();
    chk("last_one_count", 64'(bus.free_count), 64'd1);
    chk("two_req_one_free", 64'(bus.alloc_ready), 64'd0);
    step(); set_commit(1, 0, 0, 0); sample();
    chk("freed_ready", 64'(bus.alloc_ready), 64'd1);
    chk("freed_prd1", 64'(bus.alloc_prd1), 64'd5);
    chk("freed_prd2", 64'(bus.alloc_prd2), 64'd63);
    step(); set_alloc(1, 0, 0); sample();
    chk("empty_count", 64'(bus.free_count), 64'd0);
    chk("empty_zero_req_ready", 64'(bus.alloc_ready), 64'd1);

    step(); idle(); set_commit(1, 1, 0, 0); set_commit(2, 1, 0, 0); sample();
    step(); idle(); sample();
    chk("p0_free_count", 64'(bus.free_count), 64'd0);
    chk("p0_free_no_err", 64'(bus.dbl_free_err), 64'd0);

    step(); set_commit(1, 1, 32, 7); sample();
    step(); set_commit(1, 0, 0, 0); bus.flush = 1'b1; set_alloc(1, 1, 0); sample();
    chk("flush_cycle_ready", 64'(bus.alloc_ready), 64'd0);
    step(); bus.flush = 1'b0; sample();
    chk("recover_ready", 64'(bus.alloc_ready), 64'd0);
    chk("restored_b7", 64'(bus.free_pool[7]), 64'd1);
    chk("restored_b32", 64'(bus.free_pool[32]), 64'd0);
    chk("restored_b40", 64'(bus.free_pool[40]), 64'd1);
    chk("restored_b41", 64'(bus.free_pool[41]), 64'd1);
    chk("restored_count", 64'(bus.free_count), 64'd33);
    step(); idle(); sample();
    chk("run_after_recover", 64'(bus.alloc_ready), 64'd1);

    step(); bus.flush = 1'b1; sample();
    step(); bus.flush = 1'b1; sample();
    step(); bus.flush = 1'b0; sample();
    chk("double_flush_hold", 64'(bus.alloc_ready), 64'd0);
    step(); sample();
    chk("double_flush_run", 64'(bus.alloc_ready), 64'd1);

    step(); set_commit(1, 1, 0, 50); sample();
    step(); idle(); sample();
    chk("dbl_free_set", 64'(bus.dbl_free_err), 64'd1);
    repeat (3) step();
    sample();
    chk("dbl_free_sticky", 64'(bus.dbl_free_err), 64'd1);

    step(); set_alloc(1, 1, 1); sample();
    step(); step(); idle(); bus.flush = 1'b1;
    step(); bus.flush = 1'b0; reset = 1'b1; set_alloc(1, 1, 1); sample();
    chk("recover_pre_reset", 64'(bus.alloc_ready), 64'd0);
    step(); reset = 1'b0; idle(); sample();
    chk("reset_count", 64'(bus.free_count), 64'd32);
    chk("reset_init_ready", 64'(bus.alloc_ready), 64'd0);
    chk("reset_err_clear", 64'(bus.dbl_free_err), 64'd0);
    step(); sample();
    chk("reset_run_ready", 64'(bus.alloc_ready), 64'd1);

    step(); set_commit(1, 1, 0, 12); set_commit(2, 1, 0, 12); sample();
    step(); idle(); sample();
    chk("same_tag_err", 64'(bus.dbl_free_err), 64'd1);
    chk("same_tag_b12", 64'(bus.free_pool[12]), 64'd1);
    chk("same_tag_count", 64'(bus.free_count), 64'd33);

    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
